// File: rtl/ft_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ft_tx_arbiter
//
// Purpose:
//   Round-robin arbiter that shares the FT600 mode-245 TX FIFO write port
//   among NUM_REQ stream sources. Every granted burst is framed as a packet:
//   one header word {HDR_MAGIC, 4'h0, grant index}, up to MAX_BURST payload
//   words, and (optionally) a 16-bit checksum trailer.
//
// Configuration macro:
//   TX_ARB_CHECKSUM_EN  - when defined, a TRAILER state appends the 16-bit
//                         sum of the payload words (carry discarded) to every
//                         packet. When undefined, packets are header+payload
//                         and no checksum register exists.
//
// Ports:
//   clk        in   system clock (single domain)
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]     requester i presents a word
//   req_data   in   [16*NUM_REQ]  payload words packed by requester index
//   req_last   in   [NUM_REQ]     word from requester i closes its packet
//   req_ready  out  [NUM_REQ]     word from requester i accepted this cycle
//   tx_en      out  write strobe to the TX FIFO
//   tx_in      out  [16]          word written to the TX FIFO
//   tx_full    in   TX FIFO full, no write allowed this cycle
//   grant      out  [NUM_REQ]     one-hot grant of current packet, 0 in IDLE
//   busy       out  state != IDLE
//   pkt_count  out  [16]          completed packets (wrapping)
// ---------------------------------------------------------------------------
module ft_tx_arbiter #(
  parameter int          NUM_REQ   = 2,
  parameter int          MAX_BURST = 16,
  parameter logic [7:0]  HDR_MAGIC = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_en,
  output logic [15:0]            tx_in,
  input  logic                   tx_full,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [15:0]            pkt_count
);

`ifdef TX_ARB_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_TRAILER} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;
`endif

  state_t       state;
  logic [3:0]   grant_idx;
  logic [3:0]   rr_ptr;
  logic [7:0]   word_cnt;
`ifdef TX_ARB_CHECKSUM_EN
  logic [15:0]  checksum;
`endif

  logic               cur_valid;
  logic               cur_last;
  logic [15:0]        cur_data;
  logic               pick_found;
  logic [3:0]         pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [3:0]         next_ptr;
  logic               xfer;
  logic               end_pkt;
  logic [2*NUM_REQ-1:0] valid_rot;

  // Select the granted requester's word, last flag and valid.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 4'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_data  = req_data[i*16 +: 16];
      end
    end
  end

  // Round-robin pick: rotate the valid vector so rr_ptr lands at bit 0,
  // take the first set bit, then map that position back to an index.
  always_comb begin
    int pos;
    pos         = 0;
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    valid_rot   = {req_valid, req_valid} >> rr_ptr;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!pick_found && valid_rot[j]) begin
        pick_found = 1'b1;
        pos        = int'(rr_ptr) + j;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        pick_idx   = 4'(pos);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_onehot[i] = pick_found && (pick_idx == 4'(i));
    end
  end

  assign next_ptr = (grant_idx == 4'(NUM_REQ-1)) ? 4'd0 : grant_idx + 4'd1;
  assign xfer     = (state == S_PAYLOAD) && cur_valid && !tx_full;
  // Last flag and burst limit hitting together still yield a single end.
  assign end_pkt  = xfer && (cur_last || (word_cnt == 8'(MAX_BURST-1)));
  assign busy     = (state != S_IDLE);

  // Write port and handshake are combinational so a payload word moves
  // into the FIFO in the same cycle it is accepted.
  always_comb begin
    tx_en     = 1'b0;
    tx_in     = cur_data;
    req_ready = '0;
    case (state)
      S_HEADER: begin
        tx_en = !tx_full;
        tx_in = {HDR_MAGIC, 4'h0, grant_idx};
      end
      S_PAYLOAD: begin
        req_ready = tx_full ? '0 : grant;
        tx_en     = xfer;
      end
`ifdef TX_ARB_CHECKSUM_EN
      S_TRAILER: begin
        tx_en = !tx_full;
        tx_in = checksum;
      end
`endif
      default: ;
    endcase
  end

  // Packet framing state machine, grant/round-robin pointer and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      word_cnt  <= '0;
      pkt_count <= '0;
`ifdef TX_ARB_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant     <= pick_onehot;
            grant_idx <= pick_idx;
            state     <= S_HEADER;
          end
        end
        S_HEADER: begin
          word_cnt <= '0;
`ifdef TX_ARB_CHECKSUM_EN
          checksum <= '0;
`endif
          if (!tx_full) state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (xfer) begin
            word_cnt <= word_cnt + 8'd1;
`ifdef TX_ARB_CHECKSUM_EN
            checksum <= checksum + cur_data;
`endif
          end
          if (end_pkt) begin
`ifdef TX_ARB_CHECKSUM_EN
            state     <= S_TRAILER;
`else
            state     <= S_IDLE;
            grant     <= '0;
            rr_ptr    <= next_ptr;
            pkt_count <= pkt_count + 16'd1;
`endif
          end
        end
`ifdef TX_ARB_CHECKSUM_EN
        S_TRAILER: begin
          if (!tx_full) begin
            state     <= S_IDLE;
            grant     <= '0;
            rr_ptr    <= next_ptr;
            pkt_count <= pkt_count + 16'd1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ft_tx_arbiter
//
// Scoreboard bench for ft_tx_arbiter (NUM_REQ=2, MAX_BURST=4). Stimulus
// pushes source words into per-requester queues and the expected TX word
// stream into exp_q; a monitor pops exp_q on every tx_en. Honours
// TX_ARB_CHECKSUM_EN when building the expected stream.
// ---------------------------------------------------------------------------
module tb_ft_tx_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int MAX_BURST = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  tx_en;
  logic [15:0]           tx_in;
  logic                  tx_full;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic [15:0]           pkt_count;

  int checks   = 0;
  int errors   = 0;
  int tx_words = 0;

  logic [16:0] src_q0[$];
  logic [16:0] src_q1[$];
  logic [15:0] exp_q[$];
  logic [15:0] pkt_words[$];
  logic [NUM_REQ-1:0] fire = '0;

  ft_tx_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_BURST(MAX_BURST),
    .HDR_MAGIC(8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_en    (tx_en),
    .tx_in    (tx_in),
    .tx_full  (tx_full),
    .grant    (grant),
    .busy     (busy),
    .pkt_count(pkt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue the staged pkt_words as one stream from requester req and push the
  // expected framed packets (split at MAX_BURST) onto the scoreboard.
  task automatic applyStimulus(input int req);
    int n;
    int i;
    int chunk;
    logic [16:0] w;
`ifdef TX_ARB_CHECKSUM_EN
    logic [15:0] sum;
`endif
    n = pkt_words.size();
    i = 0;
    while (i < n) begin
      chunk = (n - i > MAX_BURST) ? MAX_BURST : n - i;
      exp_q.push_back({8'hA5, 4'h0, 4'(req)});
`ifdef TX_ARB_CHECKSUM_EN
      sum = 16'h0;
`endif
      for (int k = 0; k < chunk; k++) begin
        exp_q.push_back(pkt_words[i+k]);
`ifdef TX_ARB_CHECKSUM_EN
        sum = sum + pkt_words[i+k];
`endif
      end
`ifdef TX_ARB_CHECKSUM_EN
      exp_q.push_back(sum);
`endif
      i = i + chunk;
    end
    for (int k = 0; k < n; k++) begin
      w = {(k == n-1), pkt_words[k]};
      if (req == 0) src_q0.push_back(w);
      else          src_q1.push_back(w);
    end
    pkt_words.delete();
  endtask

  // Monitor: scoreboard compare on every FIFO write, plus stall invariants.
  initial begin
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      if (tx_full) begin
        checkOutput("stall_tx_en", 32'(tx_en), 32'h0);
        checkOutput("stall_req_ready", 32'(req_ready), 32'h0);
      end
      if (tx_en) begin
        tx_words++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL tx_unexpected: got %h expected no write", tx_in);
        end else begin
          checkOutput("tx_word", 32'(tx_in), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Source driver: retire accepted words, present the next head of queue.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (fire[0] && src_q0.size() > 0) void'(src_q0.pop_front());
      if (fire[1] && src_q1.size() > 0) void'(src_q1.pop_front());
      req_valid[0] = (src_q0.size() > 0);
      req_data[15:0]  = (src_q0.size() > 0) ? src_q0[0][15:0] : 16'h0;
      req_last[0]     = (src_q0.size() > 0) ? src_q0[0][16]   : 1'b0;
      req_valid[1] = (src_q1.size() > 0);
      req_data[31:16] = (src_q1.size() > 0) ? src_q1[0][15:0] : 16'h0;
      req_last[1]     = (src_q1.size() > 0) ? src_q1[0][16]   : 1'b0;
    end
  end

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && src_q0.size() == 0 && src_q1.size() == 0 && !busy) && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput({name, "_done"}, 32'(n < 500), 32'h1);
  endtask

  task automatic waitTxWords(input int target, input string name);
    int n;
    n = 0;
    while (tx_words < target && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput({name, "_reached"}, 32'(n < 200), 32'h1);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    src_q0.delete();
    src_q1.delete();
    exp_q.delete();
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int base;
    int n;
    rst_n   = 1'b0;
    tx_full = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    checkOutput("rst_tx_en", 32'(tx_en), 32'h0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_pkt_count", 32'(pkt_count), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Single 3-word packet from req0.
    $display("[TB] single packet");
    pkt_words.push_back(16'h0001);
    pkt_words.push_back(16'h0002);
    pkt_words.push_back(16'h0003);
    applyStimulus(0);
    waitIdle("t1");
    checkOutput("t1_pkt_count", 32'(pkt_count), 32'd1);
    checkOutput("t1_grant", 32'(grant), 32'h0);
    checkOutput("t1_busy", 32'(busy), 32'h0);

    // Two requesters, single-word packets, alternating from reset.
    $display("[TB] round robin");
    doReset();
    pkt_words.push_back(16'h0010); applyStimulus(0);
    pkt_words.push_back(16'h0020); applyStimulus(1);
    pkt_words.push_back(16'h0011); applyStimulus(0);
    pkt_words.push_back(16'h0021); applyStimulus(1);
    waitIdle("t2");
    checkOutput("t2_pkt_count", 32'(pkt_count), 32'd4);

    // Ten words split at MAX_BURST=4 into 4,4,2.
    $display("[TB] burst split");
    for (int k = 0; k < 10; k++) pkt_words.push_back(16'h0100 + 16'(k));
    applyStimulus(0);
    waitIdle("t3");
    checkOutput("t3_pkt_count", 32'(pkt_count), 32'd7);

    // tx_full held 5 cycles mid-payload; last coincides with burst limit.
    $display("[TB] fifo full stall");
    base = tx_words;
    for (int k = 1; k <= 4; k++) pkt_words.push_back(16'h0200 + 16'(k));
    applyStimulus(0);
    waitTxWords(base + 3, "t4");
    tx_full = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #2;
    end
    checkOutput("t4_busy_stall", 32'(busy), 32'h1);
    checkOutput("t4_tx_en_stall", 32'(tx_en), 32'h0);
    tx_full = 1'b0;
    waitIdle("t4");
    checkOutput("t4_pkt_count", 32'(pkt_count), 32'd8);

    // Checksum carry wrap (trailer only exists with the macro).
    $display("[TB] checksum wrap");
    pkt_words.push_back(16'hFFFF);
    pkt_words.push_back(16'h0002);
    applyStimulus(1);
    waitIdle("t5");
    checkOutput("t5_pkt_count", 32'(pkt_count), 32'd9);

    // Reset mid-payload, then re-arbitrate from a fresh pointer.
    $display("[TB] reset mid packet");
    base = tx_words;
    for (int k = 1; k <= 4; k++) pkt_words.push_back(16'h0300 + 16'(k));
    applyStimulus(0);
    waitTxWords(base + 2, "t6");
    rst_n = 1'b0;
    #1;
    checkOutput("t6_tx_en", 32'(tx_en), 32'h0);
    checkOutput("t6_grant", 32'(grant), 32'h0);
    checkOutput("t6_busy", 32'(busy), 32'h0);
    checkOutput("t6_pkt_count", 32'(pkt_count), 32'h0);
    checkOutput("t6_req_ready", 32'(req_ready), 32'h0);
    src_q0.delete();
    src_q1.delete();
    exp_q.delete();
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    pkt_words.push_back(16'h0400); applyStimulus(0);
    pkt_words.push_back(16'h0500); applyStimulus(1);
    n = 0;
    while (!busy && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("t6_first_grant", 32'(grant), 32'h1);
    waitIdle("t6");
    checkOutput("t6_pkt_count_after", 32'(pkt_count), 32'd2);

    checkOutput("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
